// File: rtl/result_writeback_pkg.sv
// Shared definitions for the systolic-array controller and its result writeback stage:
// FSM state encoding and the RAM region map (inputs, weights, results).
package result_writeback_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } wb_state_t;

  localparam int IN_BASE_ADDR  = 0;
  localparam int W_BASE_ADDR   = 16;
  localparam int OUT_BASE_ADDR = 32;

endpackage

// File: rtl/result_writeback_if.sv
// Bundle of the writeback stage's control, PE-row ingress and RAM write port.
// master = the writeback block, slave = controller / PE array / RAM arbiter side.
interface result_writeback_if #(
  parameter int ADD_WIDTH = 6,
  parameter int ROW       = 4,
  parameter int DATA_W    = 16
);
  logic                   start;
  logic                   pe_valid;
  logic [ROW*DATA_W-1:0]  pe_data;
  logic                   pe_ready;
  logic                   grant_out;
  logic                   req_out;
  logic                   wr_en;
  logic [ADD_WIDTH:0]     wr_addr;
  logic [DATA_W-1:0]      wr_data;
  logic                   busy;
  logic                   wb_done;

  modport master (
    input  start, pe_valid, pe_data, grant_out,
    output pe_ready, req_out, wr_en, wr_addr, wr_data, busy, wb_done
  );

  modport slave (
    output start, pe_valid, pe_data, grant_out,
    input  pe_ready, req_out, wr_en, wr_addr, wr_data, busy, wb_done
  );
endinterface

// File: rtl/result_writeback_row_fifo.sv
// Small synchronous row FIFO with a synchronous flush and async reset.
// Pointers carry one wrap bit so full/empty need no separate counter.
module row_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout    = mem[rd_ptr[AW-1:0]];

  // Pointer update; flush or reset empties the FIFO without touching storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Row storage; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= din;
  end
endmodule

// File: rtl/result_writeback.sv
// Result writeback: buffers PE result rows and serialises them word by word into
// the shared RAM behind a req/grant port, row-major from OUT_BASE.
module result_writeback
  import result_writeback_pkg::*;
#(
  parameter int ADD_WIDTH  = 6,
  parameter int ROW        = 4,
  parameter int COL        = 4,
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int OUT_BASE   = OUT_BASE_ADDR
) (
  input logic               clk,
  input logic               rst,
  result_writeback_if.master bus
);
  localparam int RW   = ROW * DATA_W;
  localparam int CW   = (ROW > 1) ? $clog2(ROW) : 1;
  localparam int RIW  = (COL > 1) ? $clog2(COL) : 1;
  localparam int ACW  = $clog2(COL + 1);
  localparam logic [ADD_WIDTH:0] BASE     = OUT_BASE[ADD_WIDTH:0];
  localparam logic [CW-1:0]      COL_LAST = CW'(ROW - 1);
  localparam logic [RIW-1:0]     ROW_LAST = RIW'(COL - 1);
  localparam logic [ACW-1:0]     ROWS_JOB = ACW'(COL);

  wb_state_t          state, state_nxt;
  logic               busy, start_job, push, pop, wr_en, last_word, job_last;
  logic               fifo_full, fifo_empty;
  logic [RW-1:0]      fifo_dout, shift_data;
  logic               shift_vld;
  logic [CW-1:0]      col_idx;
  logic [RIW-1:0]     row_idx;
  logic [ACW-1:0]     rows_acc;
  logic [ADD_WIDTH:0] addr_cnt, hold_addr;
  logic [DATA_W-1:0]  hold_data;

  assign busy      = (state == S_REQ) || (state == S_WRITE);
  assign start_job = bus.start && ((state == S_IDLE) || (state == S_DONE));
  assign push      = bus.pe_valid && bus.pe_ready;
  assign wr_en     = (state == S_WRITE) && bus.grant_out && shift_vld;
  assign last_word = (col_idx == COL_LAST);
  assign job_last  = wr_en && last_word && (row_idx == ROW_LAST);
  // Refill when the shifter is idle or its last word leaves this cycle: no bubble.
  assign pop       = busy && !fifo_empty && (!shift_vld || (last_word && wr_en));

  assign bus.pe_ready = busy && !fifo_full && (rows_acc < ROWS_JOB);
  assign bus.req_out  = busy;
  assign bus.busy     = busy;
  assign bus.wb_done  = (state == S_DONE);
  assign bus.wr_en    = wr_en;
  // Address/data hold the last written value when idle; wr_en alone qualifies them.
  assign bus.wr_addr  = wr_en ? addr_cnt : hold_addr;
  assign bus.wr_data  = wr_en ? shift_data[DATA_W-1:0] : hold_data;

  row_fifo #(.WIDTH(RW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (start_job),
    .push  (push),
    .pop   (pop),
    .din   (bus.pe_data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state: grant opens WRITE, the final word closes the job; start only from IDLE/DONE.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (bus.start)     state_nxt = S_REQ;
      S_REQ:   if (bus.grant_out) state_nxt = S_WRITE;
      S_WRITE: if (job_last)      state_nxt = S_DONE;
      S_DONE:  if (bus.start)     state_nxt = S_REQ;
      default:                    state_nxt = S_IDLE;
    endcase
  end

  // Counters, shifter and output hold registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_data <= '0;
      shift_vld  <= 1'b0;
      col_idx    <= '0;
      row_idx    <= '0;
      rows_acc   <= '0;
      addr_cnt   <= '0;
      hold_addr  <= '0;
      hold_data  <= '0;
    end else if (start_job) begin
      shift_vld  <= 1'b0;
      col_idx    <= '0;
      row_idx    <= '0;
      rows_acc   <= '0;
      addr_cnt   <= BASE;
    end else begin
      if (push) rows_acc <= rows_acc + 1'b1;
      if (pop) begin
        shift_data <= fifo_dout;
        shift_vld  <= 1'b1;
      end else if (wr_en) begin
        shift_data <= shift_data >> DATA_W;
        if (last_word) shift_vld <= 1'b0;
      end
      if (wr_en) begin
        hold_addr <= addr_cnt;
        hold_data <= shift_data[DATA_W-1:0];
        addr_cnt  <= addr_cnt + 1'b1;
        if (last_word) begin
          col_idx <= '0;
          row_idx <= row_idx + 1'b1;
        end else begin
          col_idx <= col_idx + 1'b1;
        end
      end
    end
  end
endmodule
